// File: rtl/sd_reg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sd_reg_arb_pkg
//   Shared definitions for the SD host register-port arbiter: the sequencer
//   state encoding, default widths and the default watchdog limit.
// ---------------------------------------------------------------------------
package sd_reg_arb_pkg;

    localparam int DEF_NUM_REQ        = 3;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 5;
    localparam int DEF_TIMEOUT_CYCLES = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // Index width for a vector of n entries (at least one bit).
    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// sd_reg_arbiter_if
//   Single register-file port of the SD host controller.
//   reg_req      request, held until the access completes
//   reg_rw       1 = read, 0 = write
//   reg_addr     register index
//   reg_data_in  write data towards the register file
//   reg_data_out read data from the register file
//   reg_ack      registered acknowledge, high while reg_req stays high
//   Modports: master = arbiter side, slave = register-file side.
// ---------------------------------------------------------------------------
interface sd_reg_arbiter_if
    import sd_reg_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  reg_req;
    logic                  reg_rw;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_data_in;
    logic [DATA_WIDTH-1:0] reg_data_out;
    logic                  reg_ack;

    modport master (
        output reg_req,
        output reg_rw,
        output reg_addr,
        output reg_data_in,
        input  reg_data_out,
        input  reg_ack
    );

    modport slave (
        input  reg_req,
        input  reg_rw,
        input  reg_addr,
        input  reg_data_in,
        output reg_data_out,
        output reg_ack
    );

endinterface

// File: rtl/sd_reg_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// sd_rr_pick
//   Combinational round-robin priority picker. Searches valid[] starting at
//   index ptr and wrapping around; the first set bit wins.
//   valid      in  NUM_REQ  request vector
//   ptr        in  IDX_W    highest-priority index this round (< NUM_REQ)
//   grant      out IDX_W    winning index (0 when nothing is valid)
//   any_valid  out 1        at least one request present
// ---------------------------------------------------------------------------
module sd_rr_pick
    import sd_reg_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_valid
);

    // One extra bit so ptr + k never overflows before the wrap correction.
    localparam int JW = IDX_W + 1;

    logic [JW-1:0] cand;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + JW'(k);
            if (cand >= JW'(NUM_REQ)) begin
                cand = cand - JW'(NUM_REQ);
            end
            if (!any_valid && valid[cand[IDX_W-1:0]]) begin
                grant     = cand[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_reg_arbiter.sv
// ---------------------------------------------------------------------------
// sd_reg_arbiter
//   Round-robin arbiter and sequencer sharing the SD host register-file port
//   among internal masters (index 0 = CPU bridge). One access at a time:
//   IDLE grants and latches, ISSUE holds the request until reg_ack, RELEASE
//   gives reg_ack one cycle to fall before the next grant.
//
//   Optional feature: define REG_ARB_TIMEOUT_EN to build an ISSUE watchdog
//   (TIMEOUT_CYCLES) that completes a stuck access with req_err=1, rdata=0.
//
//   Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   req_valid  in   per-requester request, held until its req_done
//   req_rw     in   per-requester direction, 1 = read
//   req_addr   in   packed register indices, ADDR_WIDTH per requester
//   req_wdata  in   packed write data, DATA_WIDTH per requester
//   req_done   out  one-cycle completion pulse for the owning requester
//   req_err    out  valid with req_done, 1 = timed out
//   rdata      out  read data, held until the next completion
//   rf         if   register-file port (master modport)
//   busy       out  high whenever the sequencer is not idle
//   owner      out  current or last granted requester
// ---------------------------------------------------------------------------
module sd_reg_arbiter
    import sd_reg_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
`ifdef REG_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
    localparam int OWNER_W       = idx_width(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_done,
    output logic                             req_err,
    output logic [DATA_WIDTH-1:0]            rdata,
    sd_reg_arbiter_if.master                 rf,
    output logic                             busy,
    output logic [OWNER_W-1:0]               owner
);

    arb_state_e         state;
    logic [OWNER_W-1:0] rr_ptr;
    logic [OWNER_W-1:0] pick_idx;
    logic               pick_any;
    logic [OWNER_W-1:0] next_ptr;

    sd_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWNER_W)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (pick_idx),
        .any_valid (pick_any)
    );

    // Pointer moves just past the winner so it loses to any other pending
    // requester next round.
    assign next_ptr = (pick_idx == OWNER_W'(NUM_REQ - 1)) ? '0
                                                          : pick_idx + OWNER_W'(1);

`ifdef REG_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign req_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            busy           <= 1'b0;
            req_done       <= '0;
            rdata          <= '0;
            rf.reg_req     <= 1'b0;
            rf.reg_rw      <= 1'b0;
            rf.reg_addr    <= '0;
            rf.reg_data_in <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            req_err        <= 1'b0;
            tmo_cnt        <= '0;
`endif
        end else begin
            // Completion outputs are single-cycle pulses by default.
            req_done <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            req_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        rf.reg_rw      <= req_rw[pick_idx];
                        rf.reg_addr    <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        rf.reg_data_in <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        rf.reg_req     <= 1'b1;
                        owner          <= pick_idx;
                        rr_ptr         <= next_ptr;
                        busy           <= 1'b1;
                        state          <= ISSUE;
`ifdef REG_ARB_TIMEOUT_EN
                        tmo_cnt        <= '0;
`endif
                    end
                end

                ISSUE: begin
                    // Ack has priority over the watchdog when both land together.
                    if (rf.reg_ack) begin
                        if (rf.reg_rw) begin
                            rdata <= rf.reg_data_out;
                        end
                        req_done[owner] <= 1'b1;
                        rf.reg_req      <= 1'b0;
                        state           <= RELEASE;
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
                        rdata           <= '0;
                        req_err         <= 1'b1;
                        req_done[owner] <= 1'b1;
                        rf.reg_req      <= 1'b0;
                        state           <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end

                RELEASE: begin
                    // reg_ack from the finished access is still high here.
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sd_reg_arbiter.md
# sd_reg_arbiter

Round-robin arbiter and transaction sequencer that shares the SD host controller's single register-file port (req/rw/addr/data_in/data_out/ack) among several internal masters: CPU bridge, command engine and data engine. It latches one requester's access, drives the register-file handshake, returns read data, and releases the port before granting the next master. It sits directly in front of the register file, and all register traffic passes through it.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters; index 0 = CPU bridge.
- DATA_WIDTH, 32, register word width.
- ADDR_WIDTH, 5, register index width.
- TIMEOUT_CYCLES, 15, watchdog limit in ISSUE (only with REG_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester access request; held until the matching req_done.
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed register indices; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_done  out  NUM_REQ  one-cycle completion pulse for the owning requester.
- req_err  out  1  valid with req_done; 1 = timed out.
- rdata  out  DATA_WIDTH  read data; valid with req_done and held until the next completion.
- reg_req, reg_rw  out  1  to the register file.
- reg_addr  out  ADDR_WIDTH  to the register file.
- reg_data_in  out  DATA_WIDTH  write data to the register file.
- reg_data_out  in  DATA_WIDTH  read data from the register file.
- reg_ack  in  1  register-file acknowledge; registered, and stays high while reg_req stays high.
- busy  out  1  high in any state other than IDLE.
- owner  out  clog2(NUM_REQ)  index of the current or last granted requester.

## Operation
- Reset values: every output is 0, the state is IDLE, and the round-robin pointer is 0.
- IDLE:
  - If any req_valid bit is set, pick a winner by round robin, searching from the pointer upward with wrap-around.
  - Latch the winner's rw, addr and wdata into reg_rw, reg_addr and reg_data_in.
  - Set owner and reg_req to 1, move to ISSUE, and set the pointer to winner+1 mod NUM_REQ.
- ISSUE:
  - reg_req stays 1 and reg_rw, reg_addr and reg_data_in stay stable.
  - When reg_ack is sampled at 1:
    - For a read, capture reg_data_out into rdata. For a write, rdata is unchanged.
    - Pulse req_done[owner] with req_err=0, drop reg_req, and move to RELEASE.
- RELEASE: spend one cycle letting reg_ack fall, then return to IDLE. No grant is made in RELEASE.
- Each requester must keep req_valid high until its req_done. If it drops req_valid earlier, the latched transaction still completes and req_done still pulses. Requests that arrive while busy are queued implicitly in the held req_valid lines.
- A requester that re-asserts immediately after its req_done loses to any other pending requester, because the pointer has advanced past it.
- reg_ack seen in IDLE or RELEASE is ignored.
- Reset mid-transaction: everything returns to reset values immediately, no req_done pulses, and the register-file request is abandoned.

## Timing
- Request sampled in IDLE at edge 0:
  - reg_req is high after edge 0.
  - The register file acks at edge 1.
  - The ack is sampled at edge 2, giving req_done high for the cycle after edge 2.
- Latency is 3 cycles from the sampled request to req_done. Sustained throughput is one access per 4 cycles.
- req_done is exactly one cycle wide, and at most one bit is set at a time.

## Configuration
- REG_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle without ack.
  - When the counter equals TIMEOUT_CYCLES, the block pulses req_done[owner] with req_err=1 and rdata=0, drops reg_req, and enters RELEASE.
  - If ack and timeout occur in the same cycle, ack wins and req_err=0.
- REG_ARB_TIMEOUT_EN undefined: ISSUE waits indefinitely, req_err is tied to 0, and no counter is built.

## Structure
- Package sd_reg_arb_pkg: state enum (IDLE, ISSUE, RELEASE), the default width constants, and the default timeout value.
- Sub-module sd_rr_pick: combinational round-robin priority picker with inputs valid[NUM_REQ] and ptr, and outputs grant index and any_valid.
- The top level holds the FSM, the latches and the timeout counter.

## Test plan
- Single write: requester 1 writes addr 5'h03 with 32'h1234_0011. reg_req is high for 2 cycles with those values, req_done[1] pulses 3 cycles after valid, and a later read of 5'h03 returns 32'h1234_0011.
- Contention: all three requesters valid at once from reset. Grants go in order 0, 1, 2, each done 4 cycles apart. Requester 0 then re-requests while 1 and 2 are still pending and is served last.
- Read data hold: requester 2 reads 5'h18 holding 32'hCAFE_0005. rdata equals that value with req_done[2] and holds it through a following write by requester 0.
- Early drop: requester 0 deasserts req_valid one cycle after its grant. The transaction still completes and req_done[0] pulses once.
- Mid-op reset: reset asserted while in ISSUE. reg_req, busy and req_done go to 0 immediately. After release, a pending request is granted starting from pointer 0.
- Timeout (macro on, TIMEOUT_CYCLES=15): reg_ack held at 0. req_done pulses with req_err=1 and rdata=0 after 15 ISSUE cycles, and the next requester is then served normally.
